// File: rtl/memory.sv
// memory: word-addressed data memory for the 16-bit datapath.
// One combinational read port, one synchronous write port with byte
// enables, and an asynchronous active-low clear of the whole array.
module memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] out,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be
);

    // Index width; a single-word memory still needs a 1-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Byte enables only make sense for a two-byte word, and the
    // modulo decode relies on a power-of-two depth.
    generate
        if (DATA_W != 16) begin : g_bad_width
            $error("memory: DATA_W must be 16");
        end
        if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("memory: DEPTH must be a power of two");
        end
        if (IDX_W > ADDR_W) begin : g_bad_addr
            $error("memory: DEPTH exceeds 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Address decode is modulo DEPTH: keep only the low index bits.
    assign rd_idx = addr[IDX_W-1:0];
    assign wr_idx = wr_addr[IDX_W-1:0];

    // Upper address bits are deliberately ignored (aliasing).
    generate
        if (IDX_W < ADDR_W) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^{addr[ADDR_W-1:IDX_W], wr_addr[ADDR_W-1:IDX_W]};
        end
    endgenerate

    // Combinational read; no bypass of wr_data, so a same-address
    // write shows up only after the edge that stores it.
    assign out = mem[rd_idx];

    // Asynchronous clear of every word; otherwise merge enabled bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            if (wr_be[0]) begin
                mem[wr_idx][7:0] <= wr_data[7:0];
            end
            if (wr_be[1]) begin
                mem[wr_idx][15:8] <= wr_data[15:8];
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// tb_memory: self-checking bench for memory (table vectors, hand
// sequences for multi-cycle corners, randomized run against a model).
module tb_memory;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] out;
    logic        we;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;

    int errors;
    int checks;

    // Reference model: plain array of words, indexed modulo DEPTH.
    logic [15:0] model [DEPTH];

    memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .out    (out),
        .we     (we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be  (wr_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] ra;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int unsigned idx(input logic [15:0] a);
        return int'(a) % DEPTH;
    endfunction

    // Model store: replace enabled bytes using a mask.
    task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] mask;
        mask = (be[0] ? 16'h00FF : 16'h0000) | (be[1] ? 16'hFF00 : 16'h0000);
        model[idx(a)] = (model[idx(a)] & ~mask) | (d & mask);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b1;
        we      = 1'b0;
        addr    = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;

        vecs[0]  = '{"wr_beef_54",   1'b1, 16'd54,    16'hBEEF, 2'b11, 16'd54,   16'hBEEF};
        vecs[1]  = '{"wr_1234_37",   1'b1, 16'd37,    16'h1234, 2'b11, 16'd37,   16'h1234};
        vecs[2]  = '{"wr_a5a5_625",  1'b1, 16'd625,   16'hA5A5, 2'b11, 16'd625,  16'hA5A5};
        vecs[3]  = '{"rd_54",        1'b0, 16'd0,     16'h0000, 2'b00, 16'd54,   16'hBEEF};
        vecs[4]  = '{"be01_54",      1'b1, 16'd54,    16'h0011, 2'b01, 16'd54,   16'hBE11};
        vecs[5]  = '{"be10_54",      1'b1, 16'd54,    16'h2200, 2'b10, 16'd54,   16'h2211};
        vecs[6]  = '{"be00_37",      1'b1, 16'd37,    16'hFFFF, 2'b00, 16'd37,   16'h1234};
        vecs[7]  = '{"wrap_wr_1078", 1'b1, 16'd1078,  16'hCAFE, 2'b11, 16'd54,   16'hCAFE};
        vecs[8]  = '{"wrap_rd_1078", 1'b0, 16'd0,     16'h0000, 2'b00, 16'd1078, 16'hCAFE};
        vecs[9]  = '{"we0_625",      1'b0, 16'd625,   16'h9999, 2'b11, 16'd625,  16'hA5A5};
        vecs[10] = '{"top_addr",     1'b1, 16'hFFFF,  16'h7777, 2'b11, 16'd1023, 16'h7777};
        vecs[11] = '{"rd_0",         1'b0, 16'd0,     16'h0000, 2'b00, 16'd0,    16'h0000};

        // Power-on reset: assert away from clock edges.
        #3 rst_n = 1'b0;
        model_clear();
        #1 check("rst_during_54", out, 16'h0000);
        @(negedge clk);
        addr = 16'd37;
        #1 check("rst_during_37", out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        addr  = 16'd54;
        #1 check("rst_after_54", out, 16'h0000);
        #10 addr = 16'd37;
        #1 check("rst_after_37", out, 16'h0000);
        #9 addr = 16'd625;
        #1 check("rst_after_625", out, 16'h0000);

        // Table-driven vectors: one cycle each, checked after the edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we      = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            wr_be   = vecs[i].be;
            addr    = vecs[i].ra;
            @(posedge clk);
            #1;
            if (vecs[i].we) model_write(vecs[i].wa, vecs[i].wd, vecs[i].be);
            check(vecs[i].name, out, vecs[i].exp);
            we = 1'b0;
        end

        // Immediate read response as addr steps.
        @(negedge clk);
        addr = 16'd37;
        #1 check("step_37", out, 16'h1234);
        addr = 16'd625;
        #1 check("step_625", out, 16'hA5A5);

        // Read-during-write: old word before edge, merged word after.
        @(negedge clk);
        addr    = 16'd37;
        we      = 1'b1;
        wr_addr = 16'd37;
        wr_data = 16'h5678;
        wr_be   = 2'b11;
        #1 check("rdw_before", out, 16'h1234);
        @(posedge clk);
        #1 check("rdw_after", out, 16'h5678);
        model_write(16'd37, 16'h5678, 2'b11);
        we = 1'b0;

        // Back-to-back byte writes to word 54 (currently CAFE).
        @(negedge clk);
        addr    = 16'd54;
        we      = 1'b1;
        wr_addr = 16'd54;
        wr_data = 16'h00AA;
        wr_be   = 2'b01;
        @(posedge clk);
        #1 check("b2b_first", out, 16'hCAAA);
        wr_addr = 16'd1078;
        wr_data = 16'hBB00;
        wr_be   = 2'b10;
        @(posedge clk);
        #1 check("b2b_second", out, 16'hBBAA);
        model_write(16'd54, 16'h00AA, 2'b01);
        model_write(16'd54, 16'hBB00, 2'b10);
        we = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we      = 1'($urandom_range(0, 3) != 0);
            wr_addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) wr_addr = 16'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            wr_be   = 2'($urandom_range(0, 3));
            addr    = ($urandom_range(0, 2) == 0) ? 16'($urandom) : wr_addr ^ (16'($urandom_range(0, 1)) << 10);
            #1 check("rand_pre", out, model[idx(addr)]);
            @(posedge clk);
            #1;
            if (we) model_write(wr_addr, wr_data, wr_be);
            check("rand_post", out, model[idx(addr)]);
        end

        // Make word 54 non-zero, then reset mid-cycle with a write pending.
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 16'd54;
        wr_data = 16'h1357;
        wr_be   = 2'b11;
        addr    = 16'd54;
        @(posedge clk);
        #1 check("pre_reset_val", out, 16'h1357);
        wr_data = 16'h1111;
        #2 rst_n = 1'b0;
        #1 check("reset_immediate", out, 16'h0000);
        model_clear();
        @(posedge clk);
        #1 check("reset_no_write", out, 16'h0000);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            addr = 16'(a);
            #0.1;
            check("post_reset_sweep", out, model[a]);
        end

        // First write after release is honoured.
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 16'd5;
        wr_data = 16'h4321;
        wr_be   = 2'b11;
        addr    = 16'd5;
        @(posedge clk);
        #1 check("write_after_reset", out, 16'h4321);
        we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run cannot hang.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/memory.md
# memory

Word-addressed data memory for the 16-bit simple architecture: one combinational read port and one synchronous write port with byte enables. It sits beside the datapath, which presents an address and reads the selected word back in the same cycle. Stores happen on the clock edge. The whole array is cleared by an asynchronous active-low reset.

## Interface
- DATA_W, 16, word width in bits; fixed at 16 because byte enables assume two bytes.
- ADDR_W, 16, width of the address ports.
- DEPTH, 1024, number of words; must be a power of two and ≤ 2^ADDR_W.
- clk  input  1  single clock; all writes occur on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- addr  input  ADDR_W  read address (word index).
- out  output  DATA_W  read data; combinational function of addr and array contents.
- we  input  1  write enable, sampled on rising clk.
- wr_addr  input  ADDR_W  write address (word index).
- wr_data  input  DATA_W  write data.
- wr_be  input  2  byte enables: bit0 selects wr_data[7:0], bit1 selects wr_data[15:8].

## Operation
- Storage: DEPTH words of DATA_W bits.
- Address decode: index = address mod DEPTH, which is the low log2(DEPTH) bits. Upper address bits are ignored.
  - Reads and writes both wrap; 1024+54 aliases word 54 at the default depth.
- Read: out = mem[addr mod DEPTH] at all times, with no clock involved.
- Write: on rising clk with rst_n high and we=1, each byte whose wr_be bit is 1 is updated from wr_data.
  - Bytes whose enable bit is 0 keep their old value.
  - we=1 with wr_be=2'b00 changes nothing.
- Reset: while rst_n=0, every word reads 16'h0000, so out=16'h0000 for any addr.
  - The clear takes effect immediately on rst_n falling, without waiting for a clock.
  - Writes are ignored while rst_n=0, including on a clk edge that coincides with reset assertion.
- Read-during-write, same address:
  - Before the edge, out shows the old word.
  - After the edge, out shows the merged new word.
  - There is no write-to-read bypass of wr_data.
- No X propagation: every word has a defined value after the first reset. Before the first reset, contents are unspecified.

## Timing
- Read latency: zero cycles (combinational). out settles within the same cycle addr changes.
- Write latency: one edge. The new value is visible on out immediately after the rising clk that performs the write, when addr matches.
- Reset assertion is asynchronous. Reset release must meet recovery/removal timing to clk. The first write is honoured on the first rising clk after rst_n is high.
- Output reset value: out = 16'h0000.
- Back-to-back writes to the same word on consecutive cycles: the last write wins, and each byte is merged independently.

## Test plan
- Reset then read: assert rst_n=0, then release; step addr through 54, 37, 625 at 10-time-unit intervals → out = 16'h0000 each time.
- Write/read: write 16'hBEEF to 54, 16'h1234 to 37 and 16'hA5A5 to 625 (wr_be=2'b11); step addr through 54, 37, 625 → out = 16'hBEEF, 16'h1234, 16'hA5A5, changing immediately with addr.
- Byte enables: word 54 = 16'hBEEF; write 16'h0011 with wr_be=2'b01 → 16'hBE11; then write 16'h2200 with wr_be=2'b10 → 16'h2211.
- Wrap-around: write 16'hCAFE to wr_addr=1078 (1024+54) → reading addr=54 and addr=1078 both give 16'hCAFE.
- Read-during-write: hold addr=37 with word 37 = 16'h1234; write 16'h5678 to 37 → out is 16'h1234 before the edge and 16'h5678 after it.
- Reset mid-operation: with non-zero contents, drop rst_n between clock edges while we=1 → out goes to 16'h0000 at once, no write lands, and all words read 0 after release.
